// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - state encoding, default address map and status bit indices for mmio_bus_ctrl
package mmio_pkg;

  typedef enum logic [1:0] {IDLE, RAM_WAIT, TX_WAIT, DONE} stateT;

  localparam logic [31:0] DEF_RAM_BASE      = 32'h1001_0000;
  localparam int          DEF_RAM_BYTES     = 256;
  localparam logic [31:0] DEF_GPIO_OUT_ADDR = 32'h1001_0100;
  localparam logic [31:0] DEF_GPIO_IN_ADDR  = 32'h1001_0104;
  localparam logic [31:0] DEF_UART_TX_ADDR  = 32'h1001_0108;
  localparam logic [31:0] DEF_UART_RX_ADDR  = 32'h1001_010C;
  localparam logic [31:0] DEF_UART_ST_ADDR  = 32'h1001_0110;

  // One-hot target bit positions returned by the decoder
  localparam int TGT_RAM      = 0;
  localparam int TGT_GPIO_OUT = 1;
  localparam int TGT_GPIO_IN  = 2;
  localparam int TGT_UART_TX  = 3;
  localparam int TGT_UART_RX  = 4;
  localparam int TGT_UART_ST  = 5;
  localparam int NUM_TGT      = 6;

  localparam int ST_TX_BUSY  = 0;
  localparam int ST_RX_VALID = 1;

endpackage

// File: rtl/mmio_addr_decode.sv
// rtl/mmio_addr_decode.sv - combinational region decode: one-hot target plus illegal flag
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int                     WORD_LENGTH   = 32,
  parameter logic [WORD_LENGTH-1:0] RAM_BASE      = DEF_RAM_BASE,
  parameter int                     RAM_BYTES     = DEF_RAM_BYTES,
  parameter logic [WORD_LENGTH-1:0] GPIO_OUT_ADDR = DEF_GPIO_OUT_ADDR,
  parameter logic [WORD_LENGTH-1:0] GPIO_IN_ADDR  = DEF_GPIO_IN_ADDR,
  parameter logic [WORD_LENGTH-1:0] UART_TX_ADDR  = DEF_UART_TX_ADDR,
  parameter logic [WORD_LENGTH-1:0] UART_RX_ADDR  = DEF_UART_RX_ADDR,
  parameter logic [WORD_LENGTH-1:0] UART_ST_ADDR  = DEF_UART_ST_ADDR
) (
  input  logic [WORD_LENGTH-1:0] addr,
  input  logic                   we,
  output logic [NUM_TGT-1:0]     target,
  output logic                   illegal
);

  logic ramHit;

  // Addresses below the base wrap to large offsets, so one compare bounds both ends
  assign ramHit = (addr - RAM_BASE) < WORD_LENGTH'(RAM_BYTES);

  always_comb begin
    target  = '0;
    illegal = 1'b0;
    if (addr[1:0] != 2'b00)          illegal = 1'b1;
    else if (ramHit)                 target[TGT_RAM] = 1'b1;
    else if (addr == GPIO_OUT_ADDR)  target[TGT_GPIO_OUT] = 1'b1;
    else if (addr == GPIO_IN_ADDR) begin
      if (we) illegal = 1'b1;
      else    target[TGT_GPIO_IN] = 1'b1;
    end else if (addr == UART_TX_ADDR) begin
      if (!we) illegal = 1'b1;
      else     target[TGT_UART_TX] = 1'b1;
    end else if (addr == UART_RX_ADDR) begin
      if (we) illegal = 1'b1;
      else    target[TGT_UART_RX] = 1'b1;
    end else if (addr == UART_ST_ADDR) begin
      if (we) illegal = 1'b1;
      else    target[TGT_UART_ST] = 1'b1;
    end else                         illegal = 1'b1;
  end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// rtl/mmio_bus_ctrl.sv - multicycle load/store sequencer for RAM, GPIO and UART; MMIO_TIMEOUT_EN adds a TX-wait timeout
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int                     WORD_LENGTH    = 32,
  parameter logic [WORD_LENGTH-1:0] RAM_BASE       = DEF_RAM_BASE,
  parameter int                     RAM_BYTES      = DEF_RAM_BYTES,
  parameter logic [WORD_LENGTH-1:0] GPIO_OUT_ADDR  = DEF_GPIO_OUT_ADDR,
  parameter logic [WORD_LENGTH-1:0] GPIO_IN_ADDR   = DEF_GPIO_IN_ADDR,
  parameter logic [WORD_LENGTH-1:0] UART_TX_ADDR   = DEF_UART_TX_ADDR,
  parameter logic [WORD_LENGTH-1:0] UART_RX_ADDR   = DEF_UART_RX_ADDR,
  parameter logic [WORD_LENGTH-1:0] UART_ST_ADDR   = DEF_UART_ST_ADDR
`ifdef MMIO_TIMEOUT_EN
  ,
  parameter int                     TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [WORD_LENGTH-1:0] addr_i,
  input  logic [WORD_LENGTH-1:0] wdata_i,
  output logic [WORD_LENGTH-1:0] rdata_o,
  output logic                   ready_o,
  output logic                   err_o,
  output logic                   ram_en_o,
  output logic                   ram_we_o,
  output logic [WORD_LENGTH-1:0] ram_addr_o,
  output logic [WORD_LENGTH-1:0] ram_wdata_o,
  input  logic [WORD_LENGTH-1:0] ram_rdata_i,
  output logic [WORD_LENGTH-1:0] gpio_out_o,
  input  logic [WORD_LENGTH-1:0] gpio_in_i,
  output logic [7:0]             uart_tx_data_o,
  output logic                   uart_tx_start_o,
  input  logic                   uart_tx_busy_i,
  input  logic [7:0]             uart_rx_data_i,
  input  logic                   uart_rx_valid_i,
  output logic                   uart_rx_clear_o
);

  stateT                  state;
  logic [NUM_TGT-1:0]     target;
  logic                   illegal;
  logic                   ramReadQ;
  logic                   errQ;
  logic [7:0]             txByteQ;
  logic [WORD_LENGTH-1:0] rdataQ;
`ifdef MMIO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] waitCnt;
`endif

  mmio_addr_decode #(
    .WORD_LENGTH  (WORD_LENGTH),
    .RAM_BASE     (RAM_BASE),
    .RAM_BYTES    (RAM_BYTES),
    .GPIO_OUT_ADDR(GPIO_OUT_ADDR),
    .GPIO_IN_ADDR (GPIO_IN_ADDR),
    .UART_TX_ADDR (UART_TX_ADDR),
    .UART_RX_ADDR (UART_RX_ADDR),
    .UART_ST_ADDR (UART_ST_ADDR)
  ) uDecode (
    .addr   (addr_i),
    .we     (we_i),
    .target (target),
    .illegal(illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      ramReadQ        <= 1'b0;
      errQ            <= 1'b0;
      txByteQ         <= '0;
      rdataQ          <= '0;
      rdata_o         <= '0;
      ready_o         <= 1'b0;
      err_o           <= 1'b0;
      ram_en_o        <= 1'b0;
      ram_we_o        <= 1'b0;
      ram_addr_o      <= '0;
      ram_wdata_o     <= '0;
      gpio_out_o      <= '0;
      uart_tx_data_o  <= '0;
      uart_tx_start_o <= 1'b0;
      uart_rx_clear_o <= 1'b0;
`ifdef MMIO_TIMEOUT_EN
      waitCnt         <= '0;
`endif
    end else begin
      ready_o         <= 1'b0;
      err_o           <= 1'b0;
      ram_en_o        <= 1'b0;
      ram_we_o        <= 1'b0;
      uart_tx_start_o <= 1'b0;
      uart_rx_clear_o <= 1'b0;
      case (state)
        IDLE: if (req_i) begin
          ramReadQ <= target[TGT_RAM] & ~we_i;
          errQ     <= illegal;
          txByteQ  <= wdata_i[7:0];
          rdataQ   <= '0;
          state    <= DONE;
`ifdef MMIO_TIMEOUT_EN
          waitCnt  <= '0;
`endif
          if (target[TGT_RAM]) begin
            ram_en_o    <= 1'b1;
            ram_we_o    <= we_i;
            ram_addr_o  <= addr_i - RAM_BASE;
            ram_wdata_o <= wdata_i;
            state       <= RAM_WAIT;
          end else if (target[TGT_GPIO_OUT]) begin
            if (we_i) gpio_out_o <= wdata_i;
            else      rdataQ     <= gpio_out_o;
          end else if (target[TGT_GPIO_IN]) begin
            rdataQ <= gpio_in_i;
          end else if (target[TGT_UART_TX]) begin
            if (uart_tx_busy_i) state <= TX_WAIT;
            else begin
              uart_tx_start_o <= 1'b1;
              uart_tx_data_o  <= wdata_i[7:0];
            end
          end else if (target[TGT_UART_RX]) begin
            rdataQ          <= WORD_LENGTH'(uart_rx_data_i);
            uart_rx_clear_o <= uart_rx_valid_i;
          end else if (target[TGT_UART_ST]) begin
            rdataQ[ST_TX_BUSY]  <= uart_tx_busy_i;
            rdataQ[ST_RX_VALID] <= uart_rx_valid_i;
          end
        end
        // RAM output becomes valid during DONE, so the capture happens there
        RAM_WAIT: state <= DONE;
        TX_WAIT: begin
          if (!uart_tx_busy_i) begin
            uart_tx_start_o <= 1'b1;
            uart_tx_data_o  <= txByteQ;
            state           <= DONE;
          end
`ifdef MMIO_TIMEOUT_EN
          else if (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            errQ  <= 1'b1;
            state <= DONE;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
`endif
        end
        DONE: begin
          ready_o <= 1'b1;
          err_o   <= errQ;
          rdata_o <= ramReadQ ? ram_rdata_i : rdataQ;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
